usart_baud_gen: RTL and testbench

USART_BAUD_GEN -- requirements
Module: usart_baud_gen

---
 rtl/usart_baud_gen.sv | 103 ++++++++++
 tb/tb_usart_baud_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/usart_baud_gen.sv
// USART baud generator: divides i_fosk by UBRR+1 into rx/tx bit-enable pulses,
// and in synchronous mode drives (master) or tracks (slave) the XCK clock.
module usart_baud_gen (
  input  logic        i_fosk,
  input  logic        i_rst,
  input  logic [11:0] i_ubrr,
  input  logic        i_ubrr_wr,
  input  logic        i_u2x,
  input  logic        i_umsel,
  input  logic        i_ucpol,
  input  logic        i_xck_master,
  input  logic        i_xck,
  output logic        o_rxclk,
  output logic        o_txclk,
  output logic        o_xck_out,
  output logic        o_xck_oe
);

  logic [11:0] baud_cnt;
  logic [3:0]  div_cnt;
  logic        xck_reg;
  logic        sync1, sync2, sync3;
  logic        hist;
  logic [2:0]  cfg_q;
  logic        cfg_vld;
  logic        oe_q;
  logic        rx_q, tx_q;

  logic [2:0]  cfg;
  logic        tick, mode_chg, master, src, rise, fall, tx_hit;

  assign cfg      = {i_umsel, i_xck_master, i_ucpol};
  assign tick     = (baud_cnt == 12'd0) && !i_ubrr_wr;
  // cfg_vld keeps the first cycle after reset from looking like a mode change
  assign mode_chg = cfg_vld && (cfg != cfg_q);
  assign master   = i_umsel && i_xck_master;
  assign src      = i_xck_master ? xck_reg : sync3;
  assign rise     = src && !hist;
  assign fall     = !src && hist;
  assign tx_hit   = i_u2x ? (div_cnt[2:0] == 3'd7) : (div_cnt == 4'd15);

  always_ff @(posedge i_fosk or posedge i_rst) begin
    if (i_rst) begin
      baud_cnt <= 12'd0;
      div_cnt  <= 4'd0;
      xck_reg  <= 1'b0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      hist     <= 1'b0;
      cfg_q    <= 3'd0;
      cfg_vld  <= 1'b0;
      oe_q     <= 1'b0;
      rx_q     <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      cfg_q   <= cfg;
      cfg_vld <= 1'b1;
      oe_q    <= master;
      sync1   <= i_xck;
      sync2   <= sync1;
      sync3   <= sync2;

      if (i_ubrr_wr || tick)
        baud_cnt <= i_ubrr;
      else
        baud_cnt <= baud_cnt - 12'd1;

      if (mode_chg) begin
        div_cnt <= 4'd0;
        xck_reg <= 1'b0;
        // realign history with the new edge source so no false edge is seen
        hist    <= i_xck_master ? 1'b0 : sync2;
        rx_q    <= 1'b0;
        tx_q    <= 1'b0;
      end else begin
        if (i_ubrr_wr)
          div_cnt <= 4'd0;
        else if (tick)
          div_cnt <= div_cnt + 4'd1;

        if (tick && master)
          xck_reg <= ~xck_reg;

        hist <= src;

        if (!i_umsel) begin
          rx_q <= tick;
          tx_q <= tick && tx_hit;
        end else begin
          rx_q <= i_ucpol ? rise : fall;
          tx_q <= i_ucpol ? fall : rise;
        end
      end
    end
  end

  assign o_rxclk   = rx_q;
  assign o_txclk   = tx_q;
  assign o_xck_out = xck_reg && oe_q;
  assign o_xck_oe  = oe_q;

endmodule

// File: tb/tb_usart_baud_gen.sv
// Directed bench for usart_baud_gen: expected {rxclk,txclk,xck_out,xck_oe}
// per cycle are queued as stimulus is applied and compared on the falling edge.
module tb_usart_baud_gen;

  logic        i_fosk = 1'b0;
  logic        i_rst = 1'b1;
  logic [11:0] i_ubrr = 12'd0;
  logic        i_ubrr_wr = 1'b0;
  logic        i_u2x = 1'b0;
  logic        i_umsel = 1'b0;
  logic        i_ucpol = 1'b0;
  logic        i_xck_master = 1'b0;
  logic        i_xck = 1'b0;
  logic        o_rxclk, o_txclk, o_xck_out, o_xck_oe;

  usart_baud_gen dut (
    .i_fosk(i_fosk), .i_rst(i_rst), .i_ubrr(i_ubrr), .i_ubrr_wr(i_ubrr_wr),
    .i_u2x(i_u2x), .i_umsel(i_umsel), .i_ucpol(i_ucpol),
    .i_xck_master(i_xck_master), .i_xck(i_xck),
    .o_rxclk(o_rxclk), .o_txclk(o_txclk), .o_xck_out(o_xck_out), .o_xck_oe(o_xck_oe)
  );

  always #5 i_fosk = ~i_fosk;

  logic [3:0] sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push_exp(input logic rx, input logic tx, input logic xo, input logic oe);
    sb_q.push_back({rx, tx, xo, oe});
  endtask

  task automatic check_now(input string tag);
    logic [3:0] exp_v, obs_v;
    exp_v = sb_q.pop_front();
    obs_v = {o_rxclk, o_txclk, o_xck_out, o_xck_oe};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed rx/tx/xo/oe=%b expected %b", tag, obs_v, exp_v);
    end
  endtask

  // one clock: queue the expectation, then compare after the next rising edge
  task automatic cycle(input string tag, input logic rx, input logic tx,
                       input logic xo, input logic oe);
    push_exp(rx, tx, xo, oe);
    @(negedge i_fosk);
    check_now(tag);
  endtask

  task automatic reset_and_check(input string tag);
    i_rst = 1'b1;
    @(negedge i_fosk);
    @(negedge i_fosk);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
  endtask

  initial begin
    // async, UBRR=3, normal speed
    i_ubrr = 12'd3;
    reset_and_check("reset_async_u3");
    for (int k = 0; k < 130; k++)
      cycle("async_u3", (k % 4) == 0, (k % 64) == 60, 1'b0, 1'b0);

    // async, UBRR=0, double speed
    i_ubrr = 12'd0; i_u2x = 1'b1;
    reset_and_check("reset_async_u0");
    for (int k = 0; k < 40; k++)
      cycle("async_u0_u2x", 1'b1, (k % 8) == 7, 1'b0, 1'b0);

    // sync master, UBRR=2, ucpol=0
    i_u2x = 1'b0; i_ubrr = 12'd2; i_umsel = 1'b1; i_xck_master = 1'b1; i_ucpol = 1'b0;
    reset_and_check("reset_master");
    for (int k = 0; k < 36; k++)
      cycle("master_u2", (k % 6) == 4, (k % 6) == 1, (k % 6) < 3, 1'b1);

    // reset asserted mid-frame while XCK is high clears outputs at once
    @(posedge i_fosk);
    #1 i_rst = 1'b1;
    #1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0);
    check_now("master_async_reset");
    @(negedge i_fosk);
    i_rst = 1'b0;
    for (int k = 0; k < 18; k++)
      cycle("master_restart", (k % 6) == 4, (k % 6) == 1, (k % 6) < 3, 1'b1);

    // sync slave, ucpol=1, XCK period 20 cycles
    i_xck_master = 1'b0; i_ucpol = 1'b1; i_xck = 1'b0;
    reset_and_check("reset_slave");
    for (int k = 0; k < 66; k++) begin
      cycle("slave_p20", k >= 14 && (k % 20) == 14, k >= 24 && (k % 20) == 4, 1'b0, 1'b0);
      i_xck = (k % 20) >= 10;
    end
    i_xck = 1'b0;

    // async, UBRR=100, reload strobe with UBRR=5 mid-count
    i_umsel = 1'b0; i_ucpol = 1'b0; i_ubrr = 12'd100;
    reset_and_check("reset_async_u100");
    for (int k = 0; k < 121; k++) begin
      cycle("ubrr_write", k == 0 || (k >= 27 && ((k - 27) % 6) == 0), k == 117, 1'b0, 1'b0);
      if (k == 20) begin
        i_ubrr_wr = 1'b1; i_ubrr = 12'd5;
      end else begin
        i_ubrr_wr = 1'b0;
      end
    end

    // mode change from async to sync master: one quiet cycle, then fresh XCK
    i_ubrr = 12'd0;
    reset_and_check("reset_mode_chg");
    for (int j = 0; j < 15; j++) begin
      if (j < 5)
        cycle("mode_pre", 1'b1, 1'b0, 1'b0, 1'b0);
      else if (j == 5)
        cycle("mode_chg", 1'b0, 1'b0, 1'b0, 1'b1);
      else if (j == 6)
        cycle("mode_post", 1'b0, 1'b0, 1'b1, 1'b1);
      else
        cycle("mode_post", (j % 2) == 0, (j % 2) == 1, (j % 2) == 0, 1'b1);
      if (j == 4) begin
        i_umsel = 1'b1; i_xck_master = 1'b1; i_ucpol = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
